// File: rtl/bus_xbar_arb_pkg.sv
// Shared constants and types for the bus_xbar_arb shared-bus interconnect.
// Arbitration modes, slave-select field width and the error read word.
package bus_xbar_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // The top SLV_SEL_W address bits choose the slave.
  localparam int SLV_SEL_W = 4;

  localparam logic [63:0] BUS_ERR_DATA = 64'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_RESP
  } xbar_state_e;

  // Index width that stays legal when there is only one requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_xbar_arb_rr_arbiter.sv
// NM-wide combinational winner pick (fixed priority or round-robin).
// The pointer register remembers the last grant for round-robin rotation.
module bus_rr_arbiter
  import bus_xbar_arb_pkg::*;
#(
  parameter int NM       = 2,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int IW       = idx_w(NM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NM-1:0] req_i,
  input  logic          take_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    if (ARB_MODE == ARB_RR) begin
      // Walk backwards so the nearest candidate after the pointer wins last.
      for (int k = NM; k >= 1; k--) begin
        if (req_i[(int'(ptr_q) + k) % NM]) begin
          vld_o = 1'b1;
          idx_o = IW'((int'(ptr_q) + k) % NM);
        end
      end
    end else begin
      for (int i = NM - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          vld_o = 1'b1;
          idx_o = IW'(i);
        end
      end
    end
    ptr_d = (take_i && vld_o) ? idx_o : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IW'(NM - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bus_xbar_arb.sv
// Shared-bus interconnect: NM masters arbitrate for one path to NS slaves.
// One transaction in flight; unmapped or timed-out accesses end with an error ack.
module bus_xbar_arb
  import bus_xbar_arb_pkg::*;
#(
  parameter int NM       = 2,
  parameter int NS       = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM-1:0]        m_req_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*ADDR_W-1:0] m_addr_i,
  input  logic [NM*DATA_W-1:0] m_wdata_i,
  output logic [NM*DATA_W-1:0] m_rdata_o,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [NM-1:0]        m_hold_o,
  output logic [NS-1:0]        s_req_o,
  output logic                 s_we_o,
  output logic [ADDR_W-1:0]    s_addr_o,
  output logic [DATA_W-1:0]    s_wdata_o,
  input  logic [NS*DATA_W-1:0] s_rdata_i,
  input  logic [NS-1:0]        s_ready_i
);

  localparam int MW = idx_w(NM);
  localparam int LW = ADDR_W - SLV_SEL_W;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(BUS_ERR_DATA);

  xbar_state_e          state_q, state_d;
  logic [MW-1:0]        gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [LW-1:0]        laddr_q, laddr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [SLV_SEL_W-1:0] sel_q, sel_d;
  logic                 unm_q, unm_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [NS-1:0]        s_req_q, s_req_d;
  logic [NM-1:0]        ack_q, ack_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  logic                 arb_vld, arb_take;
  logic [MW-1:0]        arb_idx;
  logic [ADDR_W-1:0]    pick_addr;
  logic [DATA_W-1:0]    pick_wdata;
  logic                 pick_we;
  logic [SLV_SEL_W-1:0] dec_sel;
  logic                 dec_unm;
  logic                 rdy_sel;
  logic [DATA_W-1:0]    rd_sel;

  bus_rr_arbiter #(
    .NM       (NM),
    .ARB_MODE (ARB_MODE),
    .IW       (MW)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  (m_req_i),
    .take_i (arb_take),
    .vld_o  (arb_vld),
    .idx_o  (arb_idx)
  );

  // Winner's request fields and the selected slave's response, as explicit muxes.
  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    pick_we    = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (arb_idx == MW'(i)) begin
        pick_addr  = m_addr_i[i*ADDR_W +: ADDR_W];
        pick_wdata = m_wdata_i[i*DATA_W +: DATA_W];
        pick_we    = m_we_i[i];
      end
    end
    dec_sel = pick_addr[ADDR_W-1 -: SLV_SEL_W];
    dec_unm = (int'(dec_sel) >= NS);

    rdy_sel = 1'b0;
    rd_sel  = '0;
    for (int s = 0; s < NS; s++) begin
      if (sel_q == SLV_SEL_W'(s)) begin
        rdy_sel = s_ready_i[s];
        rd_sel  = s_rdata_i[s*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    laddr_d  = laddr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    unm_d    = unm_q;
    tmo_d    = tmo_q;
    s_req_d  = s_req_q;
    ack_d    = '0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    arb_take = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          arb_take = 1'b1;
          gnt_d    = arb_idx;
          we_d     = pick_we;
          laddr_d  = pick_addr[LW-1:0];
          wdata_d  = pick_wdata;
          sel_d    = dec_sel;
          unm_d    = dec_unm;
          tmo_d    = '0;
          for (int s = 0; s < NS; s++) s_req_d[s] = !dec_unm && (dec_sel == SLV_SEL_W'(s));
          state_d  = ST_XFER;
        end
      end
      ST_XFER: begin
        if (unm_q || rdy_sel || (tmo_q == TW'(TIMEOUT - 1))) begin
          s_req_d = '0;
          state_d = ST_RESP;
          for (int i = 0; i < NM; i++) ack_d[i] = (gnt_q == MW'(i));
          // A ready slave wins over a timeout landing in the same cycle.
          if (!unm_q && rdy_sel) begin
            err_d   = 1'b0;
            rdata_d = we_q ? ERR_WORD : rd_sel;
          end else begin
            err_d   = 1'b1;
            rdata_d = ERR_WORD;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      laddr_q <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      unm_q   <= 1'b0;
      tmo_q   <= '0;
      s_req_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      laddr_q <= laddr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      unm_q   <= unm_d;
      tmo_q   <= tmo_d;
      s_req_q <= s_req_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Response lanes: only the granted master sees ack/err/rdata, for one cycle.
  for (genvar g = 0; g < NM; g++) begin : g_m
    assign m_ack_o[g]                    = ack_q[g];
    assign m_err_o[g]                    = ack_q[g] & err_q;
    assign m_rdata_o[g*DATA_W +: DATA_W] = ack_q[g] ? rdata_q : '0;
    assign m_hold_o[g]                   = m_req_i[g] & ~ack_q[g];
  end

  assign s_req_o   = s_req_q;
  assign s_we_o    = we_q;
  assign s_addr_o  = {{SLV_SEL_W{1'b0}}, laddr_q};
  assign s_wdata_o = wdata_q;

endmodule

// File: tb/tb_bus_xbar_arb.sv
// Bench for bus_xbar_arb: a fixed-priority and a round-robin instance driven by
// per-master transaction queues, checked against a transaction-level model.
module tb_bus_xbar_arb;

  localparam int NM  = 3;
  localparam int NS  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_req   [2];
  logic [NM-1:0]    m_we    [2];
  logic [NM*AW-1:0] m_addr  [2];
  logic [NM*DW-1:0] m_wdata [2];
  logic [NM*DW-1:0] m_rdata [2];
  logic [NM-1:0]    m_ack   [2];
  logic [NM-1:0]    m_err   [2];
  logic [NM-1:0]    m_hold  [2];
  logic [NS-1:0]    s_req   [2];
  logic             s_we    [2];
  logic [AW-1:0]    s_addr  [2];
  logic [DW-1:0]    s_wdata [2];
  logic [NS*DW-1:0] s_rdata [2];
  logic [NS-1:0]    s_ready [2];

  bus_xbar_arb #(.NM(NM), .NS(NS), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(TMO)) u_fix (
    .clk(clk), .rst(rst),
    .m_req_i(m_req[0]), .m_we_i(m_we[0]), .m_addr_i(m_addr[0]), .m_wdata_i(m_wdata[0]),
    .m_rdata_o(m_rdata[0]), .m_ack_o(m_ack[0]), .m_err_o(m_err[0]), .m_hold_o(m_hold[0]),
    .s_req_o(s_req[0]), .s_we_o(s_we[0]), .s_addr_o(s_addr[0]), .s_wdata_o(s_wdata[0]),
    .s_rdata_i(s_rdata[0]), .s_ready_i(s_ready[0]));

  bus_xbar_arb #(.NM(NM), .NS(NS), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(TMO)) u_rr (
    .clk(clk), .rst(rst),
    .m_req_i(m_req[1]), .m_we_i(m_we[1]), .m_addr_i(m_addr[1]), .m_wdata_i(m_wdata[1]),
    .m_rdata_o(m_rdata[1]), .m_ack_o(m_ack[1]), .m_err_o(m_err[1]), .m_hold_o(m_hold[1]),
    .s_req_o(s_req[1]), .s_we_o(s_we[1]), .s_addr_o(s_addr[1]), .s_wdata_o(s_wdata[1]),
    .s_rdata_i(s_rdata[1]), .s_ready_i(s_ready[1]));

  // w = XFER cycles the slave waits before raising ready (>= TMO never answers).
  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            w;
  } txn_t;

  typedef struct {
    int   m;
    txn_t t;
  } exp_t;

  txn_t          mq [NM][$];
  logic [DW-1:0] sdata [NS];
  int            total = 0;
  int            bad   = 0;

  function automatic txn_t mk(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd, input int w);
    txn_t t;
    t.addr = a; t.we = we; t.wdata = wd; t.w = w;
    return t;
  endfunction

  task automatic clear_q();
    for (int i = 0; i < NM; i++) mq[i].delete();
    for (int s = 0; s < NS; s++) sdata[s] = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_req[d] = '0; m_we[d] = '0; m_addr[d] = '0; m_wdata[d] = '0;
      s_rdata[d] = '0; s_ready[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_master(input int d, input int i, input txn_t t);
    m_req[d][i]             = 1'b1;
    m_we[d][i]              = t.we;
    m_addr[d][i*AW +: AW]   = t.addr;
    m_wdata[d][i*DW +: DW]  = t.wdata;
  endtask

  // Runs every queued transaction on instance d (0 fixed, 1 round-robin) after a reset.
  task automatic run_txns(input int d, input string nm);
    exp_t exq[$];
    int rem[NM];
    int last, pick, cyc, xc, prev, slv, xexp;
    bit first, mapped;
    exp_t cur;
    logic [NS-1:0] rdy, oh_s;
    logic [NM-1:0] oh_m;
    logic [NM*DW-1:0] erd;
    logic eerr;

    do_reset();
    for (int i = 0; i < NM; i++) rem[i] = mq[i].size();
    last = NM - 1;
    forever begin
      pick = -1;
      for (int k = 1; k <= NM; k++) begin
        int j;
        j = (d == 0) ? (k - 1) : ((last + k) % NM);
        if (pick < 0 && rem[j] > 0) pick = j;
      end
      if (pick < 0) break;
      exq.push_back('{pick, mq[pick][mq[pick].size() - rem[pick]]});
      rem[pick]--;
      last = pick;
    end

    for (int s = 0; s < NS; s++) s_rdata[d][s*DW +: DW] = sdata[s];
    for (int i = 0; i < NM; i++) if (mq[i].size() > 0) set_master(d, i, mq[i][0]);
    cyc = 0; xc = 0; prev = 0; first = 1'b1;

    while (exq.size() > 0) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        total++; bad++;
        $display("FAIL %s watchdog: %0d transactions never acked", nm, exq.size());
        break;
      end
      cur    = exq[0];
      slv    = int'(cur.t.addr[AW-1 -: 4]);
      mapped = (slv < NS);
      xexp   = !mapped ? 1 : ((cur.t.w < TMO) ? cur.t.w + 1 : TMO);
      oh_s   = '0;
      if (mapped) oh_s[slv] = 1'b1;
      oh_m   = '0;
      oh_m[cur.m] = 1'b1;

      rdy = NS'($urandom);
      if (s_req[d] != '0) begin
        xc++;
        total++;
        if (s_req[d] !== oh_s || s_we[d] !== cur.t.we || s_wdata[d] !== cur.t.wdata ||
            s_addr[d] !== {4'h0, cur.t.addr[AW-5:0]}) begin
          bad++;
          $display("FAIL %s slave_bus: req=%b we=%b addr=%h wdata=%h want req=%b we=%b addr=%h wdata=%h",
                   nm, s_req[d], s_we[d], s_addr[d], s_wdata[d], oh_s, cur.t.we,
                   {4'h0, cur.t.addr[AW-5:0]}, cur.t.wdata);
        end
      end
      if (mapped) rdy[slv] = (s_req[d] != '0) && (xc - 1 == cur.t.w);
      s_ready[d] = rdy;

      total++;
      if (m_ack[d] != '0) begin
        if (m_hold[d] !== (m_req[d] & ~oh_m)) begin
          bad++;
          $display("FAIL %s hold_at_ack: got %b want %b", nm, m_hold[d], m_req[d] & ~oh_m);
        end
      end else if (m_hold[d] !== m_req[d]) begin
        bad++;
        $display("FAIL %s hold: got %b want %b", nm, m_hold[d], m_req[d]);
      end

      if (m_ack[d] != '0) begin
        eerr = !mapped || (cur.t.w >= TMO);
        erd  = '0;
        if (!eerr && !cur.t.we) erd[cur.m*DW +: DW] = sdata[slv];
        total++;
        if (m_ack[d] !== oh_m || m_err[d] !== (eerr ? oh_m : '0) || m_rdata[d] !== erd) begin
          bad++;
          $display("FAIL %s response: ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h",
                   nm, m_ack[d], m_err[d], m_rdata[d], oh_m, eerr ? oh_m : '0, erd);
        end
        total++;
        if (xc !== (mapped ? xexp : 0) || (cyc - prev) !== (first ? xexp + 1 : xexp + 2)) begin
          bad++;
          $display("FAIL %s timing: s_req cycles=%0d gap=%0d want s_req cycles=%0d gap=%0d",
                   nm, xc, cyc - prev, mapped ? xexp : 0, first ? xexp + 1 : xexp + 2);
        end
        void'(mq[cur.m].pop_front());
        if (mq[cur.m].size() > 0) set_master(d, cur.m, mq[cur.m][0]);
        else m_req[d][cur.m] = 1'b0;
        void'(exq.pop_front());
        xc = 0; prev = cyc; first = 1'b0;
      end
    end
    s_ready[d] = '0;
    m_req[d]   = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (s_req[d] !== '0 || s_we[d] !== 1'b0 || s_addr[d] !== '0 || s_wdata[d] !== '0) begin
        bad++;
        $display("FAIL reset_slave_side dut%0d: req=%b we=%b addr=%h wdata=%h want zeros",
                 d, s_req[d], s_we[d], s_addr[d], s_wdata[d]);
      end
      total++;
      if (m_ack[d] !== '0 || m_err[d] !== '0 || m_rdata[d] !== '0 || m_hold[d] !== '0) begin
        bad++;
        $display("FAIL reset_master_side dut%0d: ack=%b err=%b rdata=%h hold=%b want zeros",
                 d, m_ack[d], m_err[d], m_rdata[d], m_hold[d]);
      end
    end
  endtask

  task automatic test_fixed_same_cycle();
    clear_q();
    sdata[1] = 32'hDEAD_BEEF;
    mq[0].push_back(mk(32'h1000_0004, 1'b0, 32'h0, 0));
    mq[1].push_back(mk(32'h1000_0004, 1'b0, 32'h0, 0));
    run_txns(0, "fixed_same_cycle");
  endtask

  task automatic test_rr_order();
    clear_q();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NM; i++)
        mq[i].push_back(mk({4'(i), 28'($urandom)}, 1'b0, 32'h0, 0));
    run_txns(1, "rr_order");
  endtask

  task automatic test_gpio_write();
    clear_q();
    mq[0].push_back(mk(32'h2000_0000, 1'b1, 32'h5, 0));
    run_txns(0, "gpio_write");
  endtask

  task automatic test_unmapped();
    clear_q();
    mq[1].push_back(mk(32'h7000_0000, 1'b0, 32'h0, 0));
    mq[2].push_back(mk(32'h3000_0010, 1'b0, 32'h0, 0));
    run_txns(1, "unmapped");
  endtask

  task automatic test_timeout();
    clear_q();
    mq[0].push_back(mk(32'h1000_0010, 1'b0, 32'h0, TMO));
    mq[0].push_back(mk(32'h1000_0010, 1'b0, 32'h0, 0));
    mq[0].push_back(mk(32'h0000_0020, 1'b0, 32'h0, TMO - 1));
    mq[1].push_back(mk(32'h2000_0004, 1'b1, 32'hA5A5_0001, TMO + 1));
    run_txns(0, "timeout");
  endtask

  task automatic test_random();
    for (int rep = 0; rep < 6; rep++) begin
      clear_q();
      for (int i = 0; i < NM; i++) begin
        int k;
        k = $urandom_range(0, 3);
        for (int n = 0; n < k; n++)
          mq[i].push_back(mk({4'($urandom_range(0, 4)), 28'($urandom)}, 1'($urandom),
                             32'($urandom), $urandom_range(0, TMO + 1)));
      end
      run_txns(rep % 2, "random");
    end
  endtask

  task automatic test_reset_mid_xfer();
    int guard;
    do_reset();
    m_req[1]             = 3'b100;
    m_we[1]              = 3'b000;
    m_addr[1][2*AW +: AW] = 32'h1000_0040;
    s_ready[1]           = '0;
    guard = 0;
    while (s_req[1] == '0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (s_req[1] !== 3'b010) begin
      bad++;
      $display("FAIL mid_xfer_entry: s_req=%b want %b", s_req[1], 3'b010);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (s_req[1] !== '0 || s_we[1] !== 1'b0 || s_addr[1] !== '0 || s_wdata[1] !== '0 ||
        m_ack[1] !== '0 || m_err[1] !== '0 || m_rdata[1] !== '0) begin
      bad++;
      $display("FAIL mid_xfer_reset: req=%b addr=%h ack=%b err=%b rdata=%h want zeros",
               s_req[1], s_addr[1], m_ack[1], m_err[1], m_rdata[1]);
    end
    rst = 1'b0;
    m_req[1] = '0;
    guard = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_ack[1] != '0 || s_req[1] != '0) guard++;
    end
    total++;
    if (guard !== 0) begin
      bad++;
      $display("FAIL mid_xfer_no_ack: %0d cycles with activity want 0", guard);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_req[d] = '0; m_we[d] = '0; m_addr[d] = '0; m_wdata[d] = '0;
      s_rdata[d] = '0; s_ready[d] = '0;
    end
    test_reset();
    test_fixed_same_cycle();
    test_rr_order();
    test_gpio_write();
    test_unmapped();
    test_timeout();
    test_random();
    test_reset_mid_xfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
